demon_baby_button_conditioner: RTL and testbench



---
 rtl/demon_baby_pkg.sv | 21 ++
 rtl/demon_baby_button_channel.sv | 147 ++++++++++++++
 rtl/demon_baby_button_conditioner.sv | 37 +++
 tb/tb_demon_baby_button_conditioner.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demon_baby_pkg.sv
// Shared types and default timing for the demon-baby input path.
// Defaults assume a 100 MHz clock: 1 ms debounce, 100 ms long press, 10 ms repeat.
package demon_baby_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    localparam int CLK_HZ                = 100_000_000;
    localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 1000;
    localparam int DEF_LONG_PRESS_CYCLES = CLK_HZ / 10;
    localparam int DEF_REPEAT_CYCLES     = CLK_HZ / 100;

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demon_baby_button_channel.sv
// One button: 2-flop sync, debounce, IDLE/PRESSED/HELD hold FSM and optional repeat.
// Auto-repeat is built only when DEMON_BABY_AUTO_REPEAT_EN is defined.
module demon_baby_button_channel
    import demon_baby_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int DEB_W  = cnt_w(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_w(LONG_PRESS_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_param_check
        $error("demon_baby_button_channel: inconsistent timing parameters");
    end

    logic              sync1_q, sync2_q, stable_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic              level_q, press_q, release_q, long_q;
    logic              press_d, release_d, long_d;
    btn_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Edges are taken from the stable level against its registered copy, so the
    // pulses line up with the cycle btn_level first shows the new value.
    assign press_d   = stable_q & ~level_q;
    assign release_d = ~stable_q & level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                stable_q  <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            level_q   <= stable_q;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // A release in the threshold cycle takes priority over the long press.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (press_d) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                end
            end
            PRESSED: begin
                if (release_d)                    state_d = IDLE;
                else if (hold_cnt_q == HOLD_LAST) state_d = HELD;
                else                              hold_cnt_d = hold_cnt_q + 1'b1;
            end
            HELD: begin
                if (release_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        long_d = (state_q == PRESSED) && !release_d && (hold_cnt_q == HOLD_LAST);
    end

`ifdef DEMON_BABY_AUTO_REPEAT_EN
    localparam int REP_W = cnt_w(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_q, rep_d;

    // Held at zero outside HELD, so entry into HELD always starts a fresh period.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_d     = 1'b0;
        if (state_q != HELD || release_d) begin
            rep_cnt_d = '0;
        end else if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            rep_d     = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;

endmodule

// File: rtl/demon_baby_button_conditioner.sv
// N_BUTTONS independent button channels; auto-repeat via DEMON_BABY_AUTO_REPEAT_EN.
module demon_baby_button_conditioner
    import demon_baby_pkg::*;
#(
    parameter int N_BUTTONS         = 4,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] long_press,
    output logic [N_BUTTONS-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        demon_baby_button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .btn_raw      (btn_raw[i]),
            .btn_level    (btn_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_press   (long_press[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_demon_baby_button_conditioner.sv
// Directed bench for demon_baby_button_conditioner (DEBOUNCE=4, LONG_PRESS=20, REPEAT=5).
// Tick index i counts rising edges after btn_raw changes; edge 1 is the first sample.
module tb_demon_baby_button_conditioner;

`ifdef DEMON_BABY_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, press_pulse, release_pulse, long_press, repeat_pulse;

    int total = 0;
    int bad   = 0;

    demon_baby_button_conditioner #(
        .N_BUTTONS        (4),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .REPEAT_CYCLES    (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        reset   = 1'b1;
        btn_raw = 4'b0000;
        repeat (3) tick();
        got = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
        total++;
        if (got !== 20'h0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", got, 20'h0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            total++;
            if (got !== 20'h0) begin
                bad++;
                $display("FAIL reset_idle t=%0d got=%h exp=%h", i, got, 20'h0);
            end
        end
    endtask

    // ch0 held 30 edges: press at 7, long at 27; release at 7 after drop.
    // With repeat: pulse 5 after long (overall 32); the one due at 37 loses to the release.
    task automatic test_clean_press();
        logic [19:0] got, exp_v;
        btn_raw = 4'b0001;
        for (int i = 1; i <= 30; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {3'b000, 1'(i >= 7), 3'b000, 1'(i == 7), 4'b0000, 3'b000, 1'(i == 27), 4'b0000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL clean_press t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {3'b000, 1'(i < 7), 4'b0000, 3'b000, 1'(i == 7), 4'b0000, 3'b000, 1'(AR && i == 2)};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL clean_release t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        logic [19:0] got, exp_v;
        for (int k = 0; k < 4; k++) begin
            btn_raw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            for (int j = 0; j < 2; j++) begin
                tick();
                got = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
                total++;
                if (got !== 20'h0) begin
                    bad++;
                    $display("FAIL bounce_quiet k=%0d got=%h exp=%h", k, got, 20'h0);
                end
            end
        end
        btn_raw = 4'b0010;
        for (int i = 1; i <= 10; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {2'b00, 1'(i >= 7), 1'b0, 2'b00, 1'(i == 7), 1'b0, 12'h000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL bounce_press t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {2'b00, 1'(i < 7), 1'b0, 4'b0000, 2'b00, 1'(i == 7), 1'b0, 8'h00};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL bounce_release t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    // ch2 held 10 edges past the press, then dropped: release only, no long press.
    task automatic test_short_tap();
        logic [19:0] got, exp_v;
        btn_raw = 4'b0100;
        for (int i = 1; i <= 17; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {1'b0, 1'(i >= 7), 2'b00, 1'b0, 1'(i == 7), 2'b00, 12'h000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL tap_press t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 15; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {1'b0, 1'(i < 7), 2'b00, 4'b0000, 1'b0, 1'(i == 7), 2'b00, 8'h00};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL tap_release t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    // ch3 held 25 edges past the press: long at 27; repeats (if built) at 32 and 37.
    task automatic test_long_press();
        logic [19:0] got, exp_v;
        btn_raw = 4'b1000;
        for (int i = 1; i <= 32; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {1'(i >= 7), 3'b000, 1'(i == 7), 3'b000, 4'b0000,
                     1'(i == 27), 3'b000, 1'(AR && i == 32), 3'b000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL long_hold t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {1'(i < 7), 3'b000, 4'b0000, 1'(i == 7), 3'b000, 4'b0000,
                     1'(AR && i == 5), 3'b000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL long_release t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

`ifdef DEMON_BABY_AUTO_REPEAT_EN
    // ch0 held 40 edges past the press: repeats at 32,37,42,47,52; release at 54 ends them.
    task automatic test_auto_repeat();
        logic [19:0] got, exp_v;
        btn_raw = 4'b0001;
        for (int i = 1; i <= 47; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {3'b000, 1'(i >= 7), 3'b000, 1'(i == 7), 4'b0000, 3'b000, 1'(i == 27),
                     3'b000, 1'(i > 27 && (i - 27) % 5 == 0)};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL repeat_hold t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 15; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {3'b000, 1'(i < 7), 4'b0000, 3'b000, 1'(i == 7), 4'b0000, 3'b000, 1'(i == 5)};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL repeat_release t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask
`endif

    // Reset lands between edges 10 cycles into PRESSED; raw stays high throughout.
    task automatic test_async_reset();
        logic [19:0] got, exp_v;
        btn_raw = 4'b0001;
        for (int i = 1; i <= 17; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {3'b000, 1'(i >= 7), 3'b000, 1'(i == 7), 12'h000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL arst_pre t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        got = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
        total++;
        if (got !== 20'h0) begin
            bad++;
            $display("FAIL arst_immediate got=%h exp=%h", got, 20'h0);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            total++;
            if (got !== 20'h0) begin
                bad++;
                $display("FAIL arst_held t=%0d got=%h exp=%h", i, got, 20'h0);
            end
        end
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {3'b000, 1'(i >= 7), 3'b000, 1'(i == 7), 12'h000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL arst_reaccept t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 10; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {3'b000, 1'(i < 7), 4'b0000, 3'b000, 1'(i == 7), 8'h00};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL arst_release t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_parallel();
        logic [19:0] got, exp_v;
        btn_raw = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {{4{1'(i >= 7)}}, {4{1'(i == 7)}}, 12'h000};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL parallel_press t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        btn_raw = 4'b0000;
        for (int i = 1; i <= 10; i++) begin
            tick();
            got   = {btn_level, press_pulse, release_pulse, long_press, repeat_pulse};
            exp_v = {{4{1'(i < 7)}}, 4'b0000, {4{1'(i == 7)}}, 8'h00};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL parallel_release t=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_tap();
        test_long_press();
`ifdef DEMON_BABY_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        test_async_reset();
        test_parallel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
